// File: rtl/tmr_vote_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmr_vote_pkg
// Brief    : Shared types and constants for the TMR voting controller.
// Revision : 1.0
// ============================================================================
package tmr_vote_pkg;

    typedef enum logic [1:0] {
        TMR    = 2'b00,
        DUPLEX = 2'b01,
        FAIL   = 2'b10
    } mode_e;

    localparam logic [1:0] NO_FAULT = 2'b11;

    function automatic logic [1:0] popcnt3(input logic [2:0] i_v);
        return {1'b0, i_v[0]} + {1'b0, i_v[1]} + {1'b0, i_v[2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/maj_vote_bus.sv
`default_nettype none
// ============================================================================
// Module   : maj_vote_bus
// Brief    : Combinational bitwise 2-of-3 majority over a W-bit bus.
// Revision : 1.0
// ============================================================================
module maj_vote_bus #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_maj
);

    assign o_maj = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule
`default_nettype wire

// File: rtl/tmr_vote_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tmr_vote_ctrl
// Brief    : Three-channel voter with TMR -> DUPLEX -> FAIL degradation and
//            a registered valid/ready output stage.
// Revision : 1.0
// ============================================================================
module tmr_vote_ctrl
    import tmr_vote_pkg::*;
#(
    parameter int W          = 8,
    parameter int MISS_LIMIT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     ch0,
    input  logic [W-1:0]     ch1,
    input  logic [W-1:0]     ch2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_err,
    output mode_e            mode,
    output logic [1:0]       fault_ch,
    input  logic             clr_fault,
    output logic [CNT_W-1:0] mis_cnt0,
    output logic [CNT_W-1:0] mis_cnt1,
    output logic [CNT_W-1:0] mis_cnt2
);

    localparam int              c_CONS_W = 8;
    localparam logic [c_CONS_W-1:0] c_LIMIT = c_CONS_W'(MISS_LIMIT);

    mode_e                      r_mode;
    mode_e                      w_mode_nxt;
    logic [1:0]                 r_fault_ch;
    logic [1:0]                 w_fault_nxt;
    logic [2:0][c_CONS_W-1:0]   r_cons;
    logic [2:0][c_CONS_W-1:0]   w_cons_nxt;
    logic [2:0][CNT_W-1:0]      r_mis;

    logic                       r_out_valid;
    logic [W-1:0]               r_out_data;
    logic                       r_out_err;

    logic [2:0][W-1:0]          w_ch;
    logic [W-1:0]               w_voted;
    logic                       w_accept;
    logic [2:0]                 w_dis;
    logic [2:0]                 w_hit;
    logic [W-1:0]               w_sel_data;
    logic                       w_sel_err;
    logic [W-1:0]               w_pair_a;
    logic [W-1:0]               w_pair_b;
    logic [2:0]                 w_pair_mask;

    assign w_ch = {ch2, ch1, ch0};

    maj_vote_bus #(
        .W (W)
    ) u_maj (
        .i_a   (ch0),
        .i_b   (ch1),
        .i_c   (ch2),
        .o_maj (w_voted)
    );

    // Surviving pair in DUPLEX; w_pair_a is always the lower-index channel.
    always_comb begin
        w_pair_a    = ch0;
        w_pair_b    = ch1;
        w_pair_mask = 3'b011;
        case (r_fault_ch)
            2'd0: begin
                w_pair_a    = ch1;
                w_pair_b    = ch2;
                w_pair_mask = 3'b110;
            end
            2'd1: begin
                w_pair_a    = ch0;
                w_pair_b    = ch2;
                w_pair_mask = 3'b101;
            end
            default: begin
                w_pair_a    = ch0;
                w_pair_b    = ch1;
                w_pair_mask = 3'b011;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= TMR;
            r_fault_ch <= NO_FAULT;
            r_cons     <= '0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_fault_ch <= w_fault_nxt;
            r_cons     <= w_cons_nxt;
        end
    end

    // Next-state, disagreement and voted-word selection
    always_comb begin
        w_mode_nxt  = r_mode;
        w_fault_nxt = r_fault_ch;
        w_cons_nxt  = r_cons;
        w_dis       = '0;
        w_hit       = '0;
        w_sel_data  = w_voted;
        w_sel_err   = 1'b0;
        case (r_mode)
            TMR: begin
                for (int i = 0; i < 3; i++) begin
                    w_dis[i] = (w_ch[i] != w_voted);
                end
                w_sel_err = (popcnt3(w_dis) >= 2'd2);
                if (w_accept) begin
                    for (int i = 0; i < 3; i++) begin
                        if (w_dis[i]) begin
                            w_cons_nxt[i] = (r_cons[i] != {c_CONS_W{1'b1}}) ?
                                            r_cons[i] + c_CONS_W'(1) : r_cons[i];
                        end else begin
                            w_cons_nxt[i] = '0;
                        end
                        w_hit[i] = w_dis[i] && (w_cons_nxt[i] >= c_LIMIT);
                    end
                    if (popcnt3(w_hit) == 2'd1) begin
                        w_mode_nxt  = DUPLEX;
                        w_fault_nxt = w_hit[0] ? 2'd0 : (w_hit[1] ? 2'd1 : 2'd2);
                        w_cons_nxt  = '0;
                    end else if (popcnt3(w_hit) >= 2'd2) begin
                        w_mode_nxt  = FAIL;
                        w_cons_nxt  = '0;
                    end
                end
            end
            DUPLEX: begin
                w_sel_data = w_pair_a;
                if (w_pair_a != w_pair_b) begin
                    w_sel_err = 1'b1;
                    w_dis     = w_pair_mask;
                    if (w_accept) begin
                        w_mode_nxt = FAIL;
                    end
                end
            end
            default: begin
                w_sel_data = w_voted;
            end
        endcase
        // Clearing wins over any transition the same-cycle accept would cause.
        if (clr_fault) begin
            w_mode_nxt  = TMR;
            w_fault_nxt = NO_FAULT;
            w_cons_nxt  = '0;
        end
    end

    // Handshake outputs
    always_comb begin
        in_ready = (r_mode != FAIL) && (!r_out_valid || out_ready);
        w_accept = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_mis       <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_err   <= w_sel_err;
                for (int i = 0; i < 3; i++) begin
                    if (w_dis[i] && (r_mis[i] != {CNT_W{1'b1}})) begin
                        r_mis[i] <= r_mis[i] + CNT_W'(1);
                    end
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign mode      = r_mode;
    assign fault_ch  = r_fault_ch;
    assign mis_cnt0  = r_mis[0];
    assign mis_cnt1  = r_mis[1];
    assign mis_cnt2  = r_mis[2];

endmodule
`default_nettype wire

// File: tb/tb_tmr_vote_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmr_vote_ctrl
// Brief    : Self-checking scenario bench for tmr_vote_ctrl with an
//            expected-output queue.
// Revision : 1.0
// ============================================================================
module tb_tmr_vote_ctrl;
    import tmr_vote_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] ch0 = '0, ch1 = '0, ch2 = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_err;
    mode_e      mode;
    logic [1:0] fault_ch;
    logic       clr_fault = 1'b0;
    logic [7:0] mis_cnt0, mis_cnt1, mis_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } exp_t;
    exp_t sb[$];
    exp_t ex;

    tmr_vote_ctrl #(.W(8), .MISS_LIMIT(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ch0       (ch0),
        .ch1       (ch1),
        .ch2       (ch2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .mode      (mode),
        .fault_ch  (fault_ch),
        .clr_fault (clr_fault),
        .mis_cnt0  (mis_cnt0),
        .mis_cnt1  (mis_cnt1),
        .mis_cnt2  (mis_cnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded, required finish earlier", $time);
        $fatal(1);
    end

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_fault = 1'b0;
        ch0 = '0; ch1 = '0; ch2 = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out: got v=%b d=%h e=%b, want 0/00/0", out_valid, out_data, out_err);
        end
        n_cmp++;
        if (mode !== TMR || fault_ch !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_mode: got mode=%0d fault=%b, want 0/11", mode, fault_ch);
        end
        n_cmp++;
        if (mis_cnt0 !== 8'd0 || mis_cnt1 !== 8'd0 || mis_cnt2 !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_mis: got %0d/%0d/%0d, want 0/0/0", mis_cnt0, mis_cnt1, mis_cnt2);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_vote();
        logic [7:0] c0[3] = '{8'hA5, 8'h0F, 8'h00};
        logic [7:0] c1[3] = '{8'hA5, 8'hFF, 8'h0F};
        logic [7:0] c2[3] = '{8'hA5, 8'h0F, 8'hF0};
        logic [7:0] ed[3] = '{8'hA5, 8'h0F, 8'h00};
        logic       ee[3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] m1[3] = '{8'd0, 8'd1, 8'd2};
        logic [7:0] m2[3] = '{8'd0, 8'd0, 8'd1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ch0 = c0[i]; ch1 = c1[i]; ch2 = c2[i];
            in_valid = 1'b1;
            sb.push_back({ed[i], ee[i]});
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                n_bad++;
                $display("FAIL vote_valid[%0d]: got out_valid=%b, want 1", i, out_valid);
            end else begin
                ex = sb.pop_front();
                if (out_data !== ex.d || out_err !== ex.e) begin
                    n_bad++;
                    $display("FAIL vote_data[%0d]: got d=%h e=%b, want d=%h e=%b", i, out_data, out_err, ex.d, ex.e);
                end
            end
            n_cmp++;
            if (mis_cnt0 !== 8'd0 || mis_cnt1 !== m1[i] || mis_cnt2 !== m2[i] || mode !== TMR) begin
                n_bad++;
                $display("FAIL vote_cnt[%0d]: got mis=%0d/%0d/%0d mode=%0d, want 0/%0d/%0d mode=0",
                         i, mis_cnt0, mis_cnt1, mis_cnt2, mode, m1[i], m2[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL vote_drop: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_degrade();
        logic [7:0] corrupt = 8'b1111_0111;
        int         n_corrupt = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ch0 = 8'h3C; ch1 = 8'h3C;
            ch2 = corrupt[i] ? 8'hC3 : 8'h3C;
            if (corrupt[i]) n_corrupt++;
            in_valid = 1'b1;
            sb.push_back({8'h3C, 1'b0});
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                n_bad++;
                $display("FAIL degrade_valid[%0d]: got out_valid=%b, want 1", i, out_valid);
            end else begin
                ex = sb.pop_front();
                if (out_data !== ex.d || out_err !== ex.e) begin
                    n_bad++;
                    $display("FAIL degrade_data[%0d]: got d=%h e=%b, want d=%h e=%b", i, out_data, out_err, ex.d, ex.e);
                end
            end
            n_cmp++;
            if (i < 7) begin
                if (mode !== TMR || fault_ch !== 2'b11 || mis_cnt2 !== 8'(n_corrupt)) begin
                    n_bad++;
                    $display("FAIL degrade_mode[%0d]: got mode=%0d fault=%b mis2=%0d, want 0/11/%0d",
                             i, mode, fault_ch, mis_cnt2, n_corrupt);
                end
            end else begin
                if (mode !== DUPLEX || fault_ch !== 2'd2 || mis_cnt2 !== 8'd7) begin
                    n_bad++;
                    $display("FAIL degrade_final: got mode=%0d fault=%b mis2=%0d, want 1/10/7",
                             mode, fault_ch, mis_cnt2);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Runs from the DUPLEX/fault_ch=2 state that test_degrade leaves behind.
    task automatic test_duplex();
        logic [7:0] c0[2] = '{8'h55, 8'h11};
        logic [7:0] c1[2] = '{8'h55, 8'h22};
        logic [7:0] c2[2] = '{8'hAA, 8'h11};
        logic [7:0] ed[2] = '{8'h55, 8'h11};
        logic       ee[2] = '{1'b0, 1'b1};
        mode_e      em[2] = '{DUPLEX, FAIL};
        logic [7:0] m01[2] = '{8'd0, 8'd1};
        for (int i = 0; i < 2; i++) begin
            ch0 = c0[i]; ch1 = c1[i]; ch2 = c2[i];
            in_valid = 1'b1;
            sb.push_back({ed[i], ee[i]});
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                n_bad++;
                $display("FAIL duplex_valid[%0d]: got out_valid=%b, want 1", i, out_valid);
            end else begin
                ex = sb.pop_front();
                if (out_data !== ex.d || out_err !== ex.e) begin
                    n_bad++;
                    $display("FAIL duplex_data[%0d]: got d=%h e=%b, want d=%h e=%b", i, out_data, out_err, ex.d, ex.e);
                end
            end
            n_cmp++;
            if (mode !== em[i] || mis_cnt0 !== m01[i] || mis_cnt1 !== m01[i] || mis_cnt2 !== 8'd7) begin
                n_bad++;
                $display("FAIL duplex_state[%0d]: got mode=%0d mis=%0d/%0d/%0d, want mode=%0d mis=%0d/%0d/7",
                         i, mode, mis_cnt0, mis_cnt1, mis_cnt2, em[i], m01[i], m01[i]);
            end
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fail_in_ready: got %b, want 0", in_ready);
        end
        ch0 = 8'h33; ch1 = 8'h33; ch2 = 8'h33;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || mode !== FAIL) begin
            n_bad++;
            $display("FAIL fail_hold: got out_valid=%b mode=%0d, want 0/2", out_valid, mode);
        end
        in_valid  = 1'b0;
        clr_fault = 1'b1;
        @(posedge clk); #1;
        clr_fault = 1'b0;
        n_cmp++;
        if (mode !== TMR || fault_ch !== 2'b11 || in_ready !== 1'b1 || mis_cnt0 !== 8'd1) begin
            n_bad++;
            $display("FAIL clr_fault: got mode=%0d fault=%b in_ready=%b mis0=%0d, want 0/11/1/1",
                     mode, fault_ch, in_ready, mis_cnt0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[3] = '{8'h34, 8'h56, 8'h78};
        do_reset();
        out_ready = 1'b0;
        ch0 = 8'h12; ch1 = 8'h12; ch2 = 8'h12;
        in_valid = 1'b1;
        sb.push_back({8'h12, 1'b0});
        @(posedge clk); #1;
        ch0 = 8'h34; ch1 = 8'h34; ch2 = 8'h34;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 8'h12 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall[%0d]: got v=%b d=%h in_ready=%b, want 1/12/0", i, out_valid, out_data, in_ready);
            end
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL release: got in_ready=%b out_valid=%b, want 1/1", in_ready, out_valid);
        end else begin
            ex = sb.pop_front();
            if (out_data !== ex.d || out_err !== ex.e) begin
                n_bad++;
                $display("FAIL release_data: got d=%h e=%b, want d=%h e=%b", out_data, out_err, ex.d, ex.e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            ch0 = vals[i]; ch1 = vals[i]; ch2 = vals[i];
            sb.push_back({vals[i], 1'b0});
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                n_bad++;
                $display("FAIL b2b_valid[%0d]: got out_valid=%b, want 1", i, out_valid);
            end else begin
                ex = sb.pop_front();
                if (out_data !== ex.d || out_err !== ex.e) begin
                    n_bad++;
                    $display("FAIL b2b_data[%0d]: got d=%h e=%b, want d=%h e=%b", i, out_data, out_err, ex.d, ex.e);
                end
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain: got out_valid=%b pending=%0d, want 0/0", out_valid, sb.size());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ch0 = 8'hFF; ch1 = 8'h00; ch2 = 8'h00;
            in_valid = 1'b1;
            sb.push_back({8'h00, 1'b0});
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                n_bad++;
                $display("FAIL ar_valid[%0d]: got out_valid=%b, want 1", i, out_valid);
            end else begin
                ex = sb.pop_front();
                if (out_data !== ex.d || out_err !== ex.e) begin
                    n_bad++;
                    $display("FAIL ar_data[%0d]: got d=%h e=%b, want d=%h e=%b", i, out_data, out_err, ex.d, ex.e);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || mode !== DUPLEX || fault_ch !== 2'd0 || mis_cnt0 !== 8'd4) begin
            n_bad++;
            $display("FAIL ar_pre: got v=%b mode=%0d fault=%b mis0=%0d, want 1/1/00/4",
                     out_valid, mode, fault_ch, mis_cnt0);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || mode !== TMR || fault_ch !== 2'b11 || mis_cnt0 !== 8'd0) begin
            n_bad++;
            $display("FAIL ar_async: got v=%b mode=%0d fault=%b mis0=%0d, want 0/0/11/0",
                     out_valid, mode, fault_ch, mis_cnt0);
        end
        sb.delete();
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_vote();
        test_degrade();
        test_duplex();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmr_vote_ctrl.md
Name: tmr_vote_ctrl

Overview:
Sequencing and fault-management controller for redundant three-channel data. Accepts W-bit words from channels 0/1/2 over a valid/ready handshake and forms the bitwise majority through a bus voter sub-module. Tracks per-channel disagreement and degrades from TMR to DUPLEX to FAIL as channels misbehave. The registered output stage feeds downstream logic through a second valid/ready handshake.

Parameters:
W, 8, data width of each channel and of out_data
MISS_LIMIT, 4, consecutive single-channel disagreements that exclude that channel (range 1..255)
CNT_W, 8, width of the saturating total-mismatch counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  channel word set valid
in_ready  out  1  controller can accept
ch0, ch1, ch2  in  W each  redundant channel words
out_valid  out  1  voted word valid
out_ready  in  1  downstream accepts
out_data  out  W  voted/selected word
out_err  out  1  out_data not trustworthy
mode  out  2  tmr_vote_pkg::mode_e (TMR/DUPLEX/FAIL)
fault_ch  out  2  excluded channel, 2'b11 = none
clr_fault  in  1  one-cycle pulse, return to TMR
mis_cnt0, mis_cnt1, mis_cnt2  out  CNT_W each  saturating total disagreements per channel

Behaviour:
- Reset (async, any time, mid-transfer included): out_valid=0, out_data=0, out_err=0, mode=TMR, fault_ch=2'b11, all mis_cnt=0, all consecutive counters=0. Held words are discarded.
- Handshake:
  - in_ready = (mode!=FAIL) & (!out_valid | out_ready). Accept = in_valid & in_ready.
  - Latency: 1 cycle from accept to out_valid.
  - out_data and out_err are stable while out_valid & !out_ready.
  - out_valid drops after the transfer unless a new accept occurs in the same cycle. Full throughput is 1 word/cycle.
- TMR (mode 2'b00):
  - voted = bitwise maj(ch0, ch1, ch2). out_data = voted.
  - Channel i disagrees when ch_i != voted.
  - 0 disagree: out_err=0; all consecutive counters cleared.
  - Exactly 1 disagrees: out_err=0. That channel's consecutive counter increments; the others clear.
  - 2 or 3 disagree: out_err=1. Consecutive counters of the disagreeing channels increment; others clear.
  - When a counter reaches MISS_LIMIT on an accept, the controller acts at the following edge:
    - If exactly one channel reaches the limit: mode goes to DUPLEX and fault_ch becomes that channel.
    - If two or more reach the limit in the same cycle: mode goes to FAIL and fault_ch stays 2'b11.
- DUPLEX (mode 2'b01):
  - Only the two non-excluded channels are compared.
  - Equal: out_data = that value, out_err=0.
  - Unequal: out_data = the lower-index remaining channel, out_err=1, both remaining channels count as disagreeing, and mode goes to FAIL at the next edge.
  - The excluded channel is ignored and not counted.
- FAIL (mode 2'b10): in_ready=0. A pending output still completes its handshake. The controller stays in FAIL until clr_fault or reset.
- mis_cnt_i: +1 per accepted word in which channel i disagrees. Saturates at all-ones. Cleared only by reset.
- clr_fault, any mode: at the next edge mode=TMR, fault_ch=2'b11, consecutive counters cleared.
  - It has priority over transitions caused by a same-cycle accept.
  - That accept is still voted and output in the pre-clear mode, and its mis_cnt updates still apply.

Decomposition:
- Package tmr_vote_pkg holds:
  - typedef enum logic [1:0] mode_e {TMR=2'b00, DUPLEX=2'b01, FAIL=2'b10}
  - localparam NO_FAULT = 2'b11
- Sub-module maj_vote_bus #(W) is a purely combinational bitwise 3-input majority. It is instantiated once.
- The FSM, counters and output register stay in tmr_vote_ctrl.

Test Plan:
- Reset then ch0=ch1=ch2=8'hA5 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_err=0, mis_cnt all 0, mode=TMR.
- ch0=8'h0F, ch1=8'hFF, ch2=8'h0F -> out_data=8'h0F, out_err=0, mis_cnt1=1. Then ch0=8'h00, ch1=8'h0F, ch2=8'hF0 -> out_data=8'h00, out_err=1, mis_cnt1=2, mis_cnt2=1.
- ch2 corrupted on 3 words, 1 clean word, then 4 more corrupted words -> mode stays TMR through the 3rd corrupt word, becomes DUPLEX with fault_ch=2 only after the 4th consecutive one, and mis_cnt2=7.
- In DUPLEX with fault_ch=2, send ch0=8'h11, ch1=8'h22 -> out_data=8'h11, out_err=1, then mode=FAIL and in_ready=0. Pulse clr_fault -> mode=TMR, fault_ch=2'b11, in_ready=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first accept and out_data unchanged. Raise out_ready -> one transfer, then back-to-back accepts resume at 1/cycle.
- Assert rst asynchronously (between edges) while out_valid=1 in DUPLEX -> out_valid=0, mode=TMR, fault_ch=2'b11, and mis_cnt=0 immediately, without waiting for a clock edge.
